// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multi-cycle MIPS controller:
// ALU operation codes (common with the ALU), opcode/funct encodings,
// FSM state enum and the decoded-instruction bundle.
package mips_ctrl_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int RF_AW_DEF = 5;

  // ALU operation codes
  localparam logic [5:0] ALUC_SLL  = 6'b000000;
  localparam logic [5:0] ALUC_SRL  = 6'b000010;
  localparam logic [5:0] ALUC_SRA  = 6'b000011;
  localparam logic [5:0] ALUC_SLLV = 6'b000100;
  localparam logic [5:0] ALUC_SRLV = 6'b000110;
  localparam logic [5:0] ALUC_SRAV = 6'b000111;
  localparam logic [5:0] ALUC_LUI  = 6'b001111;
  localparam logic [5:0] ALUC_ADD  = 6'b100000;
  localparam logic [5:0] ALUC_ADDU = 6'b100001;
  localparam logic [5:0] ALUC_SUB  = 6'b100010;
  localparam logic [5:0] ALUC_SUBU = 6'b100011;
  localparam logic [5:0] ALUC_AND  = 6'b100100;
  localparam logic [5:0] ALUC_OR   = 6'b100101;
  localparam logic [5:0] ALUC_XOR  = 6'b100110;
  localparam logic [5:0] ALUC_NOR  = 6'b100111;
  localparam logic [5:0] ALUC_SLT  = 6'b101010;
  localparam logic [5:0] ALUC_SLTU = 6'b101011;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  // R-type funct that is not an ALU op
  localparam logic [5:0] FN_JR = 6'b001000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_READ,
    S_EXEC,
    S_RETIRE
  } state_t;

  typedef enum logic [1:0] {
    A_RS,
    A_SHAMT,
    A_IMM
  } asel_t;

  typedef enum logic [1:0] {
    B_RT,
    B_IMM,
    B_ZERO
  } bsel_t;

  typedef struct packed {
    logic [5:0]  aluc;
    asel_t       a_sel;
    bsel_t       b_sel;
    logic [31:0] imm;
    logic [4:0]  wb_dst;
    logic        wb_req;
    logic        is_beq;
    logic        is_bne;
    logic        is_jr;
    logic        ovf_chk;
    logic        illegal;
  } dec_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// Combinational instruction decoder: maps an instruction word to ALU code,
// operand selects, extended immediate, writeback destination and
// branch/jump/illegal/overflow-check flags.
module mips_ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign imm16 = instr[15:0];

  // Decode opcode/funct into control bundle
  always_comb begin
    dec        = '0;
    dec.a_sel  = A_RS;
    dec.b_sel  = B_RT;
    dec.aluc   = ALUC_ADDU;
    dec.imm    = {{16{imm16[15]}}, imm16};
    unique case (op)
      OP_RTYPE: begin
        dec.wb_dst = instr[15:11];
        dec.wb_req = 1'b1;
        unique case (funct)
          ALUC_ADD, ALUC_ADDU, ALUC_SUB, ALUC_SUBU,
          ALUC_AND, ALUC_OR, ALUC_XOR, ALUC_NOR,
          ALUC_SLT, ALUC_SLTU, ALUC_SLLV, ALUC_SRLV, ALUC_SRAV: begin
            dec.aluc = funct;
          end
          ALUC_SLL, ALUC_SRL, ALUC_SRA: begin
            dec.aluc  = funct;
            dec.a_sel = A_SHAMT;
          end
          FN_JR: begin
            dec.wb_req = 1'b0;
            dec.is_jr  = 1'b1;
          end
          default: begin
            dec.wb_req  = 1'b0;
            dec.illegal = 1'b1;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU: begin
        dec.b_sel  = B_IMM;
        dec.wb_dst = instr[20:16];
        dec.wb_req = 1'b1;
        unique case (op)
          OP_ADDI:  dec.aluc = ALUC_ADD;
          OP_ADDIU: dec.aluc = ALUC_ADDU;
          OP_SLTI:  dec.aluc = ALUC_SLT;
          default:  dec.aluc = ALUC_SLTU;
        endcase
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec.b_sel  = B_IMM;
        dec.imm    = {16'b0, imm16};
        dec.wb_dst = instr[20:16];
        dec.wb_req = 1'b1;
        unique case (op)
          OP_ANDI: dec.aluc = ALUC_AND;
          OP_ORI:  dec.aluc = ALUC_OR;
          default: dec.aluc = ALUC_XOR;
        endcase
      end
      OP_LUI: begin
        dec.aluc   = ALUC_LUI;
        dec.a_sel  = A_IMM;
        dec.b_sel  = B_ZERO;
        dec.imm    = {16'b0, imm16};
        dec.wb_dst = instr[20:16];
        dec.wb_req = 1'b1;
      end
      OP_BEQ: begin
        dec.aluc   = ALUC_SUBU;
        dec.is_beq = 1'b1;
      end
      OP_BNE: begin
        dec.aluc   = ALUC_SUBU;
        dec.is_bne = 1'b1;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    dec.ovf_chk = ((dec.aluc == ALUC_ADD) || (dec.aluc == ALUC_SUB)) && !dec.illegal && !dec.is_jr;
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control FSM driving the ALU interface:
// IDLE -> DECODE -> READ -> EXEC -> RETIRE -> IDLE, one instruction at a time.
// Optional macro TRAP_OVF_EN: ADD/SUB/ADDI overflow suppresses writeback and
// raises exc_ovf at retire; otherwise exc_ovf is constant 0.
module mips_mc_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  output logic [RF_AW-1:0] rs_addr,
  output logic [RF_AW-1:0] rt_addr,
  input  logic [XLEN-1:0]  rs_data,
  input  logic [XLEN-1:0]  rt_data,
  output logic [XLEN-1:0]  alu_a,
  output logic [XLEN-1:0]  alu_b,
  output logic [5:0]       aluc,
  input  logic [XLEN-1:0]  alu_r,
  input  logic             alu_zero,
  input  logic             alu_overflow,
  output logic             wb_en,
  output logic [RF_AW-1:0] wb_addr,
  output logic [XLEN-1:0]  wb_data,
  output logic             br_taken,
  output logic [XLEN-1:0]  br_target,
  output logic             br_abs,
  output logic             done,
  output logic             illegal,
  output logic             exc_ovf
);

  state_t           state_q, state_d;
  logic [31:0]      instr_q, instr_d;
  logic             instr_ready_q, instr_ready_d;
  logic [RF_AW-1:0] rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
  logic [XLEN-1:0]  rs_val_q, rs_val_d;
  logic [XLEN-1:0]  alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [5:0]       aluc_q, aluc_d;
  logic             wb_en_q, wb_en_d;
  logic [RF_AW-1:0] wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]  wb_data_q, wb_data_d;
  logic             br_taken_q, br_taken_d;
  logic [XLEN-1:0]  br_target_q, br_target_d;
  logic             br_abs_q, br_abs_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;
  logic             exc_ovf_q, exc_ovf_d;
  logic             trap;
  dec_t             dec;

  mips_ctrl_decode u_decode (
    .instr (instr_q),
    .dec   (dec)
  );

`ifdef TRAP_OVF_EN
  assign trap = dec.ovf_chk & alu_overflow;
`else
  logic unused_ovf;
  assign unused_ovf = alu_overflow | dec.ovf_chk;
  assign trap       = 1'b0;
`endif

  // Next-state and next-output computation; retire strobes default low
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rs_val_d    = rs_val_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    aluc_d      = aluc_q;
    wb_addr_d   = wb_addr_q;
    wb_data_d   = wb_data_q;
    wb_en_d     = 1'b0;
    br_taken_d  = 1'b0;
    br_target_d = '0;
    br_abs_d    = 1'b0;
    done_d      = 1'b0;
    illegal_d   = 1'b0;
    exc_ovf_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          instr_d   = instr;
          rs_addr_d = instr[25:21];
          rt_addr_d = instr[20:16];
          state_d   = S_DECODE;
        end
      end
      S_DECODE: state_d = S_READ;
      S_READ: begin
        // Operands arrive this cycle and go straight into the registered ALU inputs
        rs_val_d = rs_data;
        aluc_d   = dec.aluc;
        unique case (dec.a_sel)
          A_SHAMT: alu_a_d = {27'b0, instr_q[10:6]};
          A_IMM:   alu_a_d = dec.imm;
          default: alu_a_d = rs_data;
        endcase
        unique case (dec.b_sel)
          B_IMM:   alu_b_d = dec.imm;
          B_ZERO:  alu_b_d = '0;
          default: alu_b_d = rt_data;
        endcase
        state_d = S_EXEC;
      end
      S_EXEC: begin
        wb_data_d  = alu_r;
        wb_addr_d  = dec.wb_dst;
        wb_en_d    = dec.wb_req && (dec.wb_dst != '0) && !trap;
        exc_ovf_d  = trap;
        br_taken_d = (dec.is_beq & alu_zero) | (dec.is_bne & ~alu_zero) | dec.is_jr;
        br_abs_d   = dec.is_jr;
        if (dec.is_jr) begin
          br_target_d = rs_val_q;
        end else if (dec.is_beq || dec.is_bne) begin
          br_target_d = {dec.imm[29:0], 2'b00};
        end
        done_d    = 1'b1;
        illegal_d = dec.illegal;
        state_d   = S_RETIRE;
      end
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    instr_ready_d = (state_d == S_IDLE);
  end

  // State and registered outputs; reset discards any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      instr_ready_q <= 1'b1;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      rs_val_q      <= '0;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      aluc_q        <= '0;
      wb_en_q       <= 1'b0;
      wb_addr_q     <= '0;
      wb_data_q     <= '0;
      br_taken_q    <= 1'b0;
      br_target_q   <= '0;
      br_abs_q      <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      exc_ovf_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_ready_q <= instr_ready_d;
      rs_addr_q     <= rs_addr_d;
      rt_addr_q     <= rt_addr_d;
      rs_val_q      <= rs_val_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      aluc_q        <= aluc_d;
      wb_en_q       <= wb_en_d;
      wb_addr_q     <= wb_addr_d;
      wb_data_q     <= wb_data_d;
      br_taken_q    <= br_taken_d;
      br_target_q   <= br_target_d;
      br_abs_q      <= br_abs_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      exc_ovf_q     <= exc_ovf_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign rs_addr     = rs_addr_q;
  assign rt_addr     = rt_addr_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign aluc        = aluc_q;
  assign wb_en       = wb_en_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data     = wb_data_q;
  assign br_taken    = br_taken_q;
  assign br_target   = br_target_q;
  assign br_abs      = br_abs_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign exc_ovf     = exc_ovf_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Directed bench for mips_mc_ctrl with a small register file and ALU model.
module tb_mips_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rs_addr, rt_addr;
  logic [31:0] rs_data, rt_data;
  logic [31:0] alu_a, alu_b;
  logic [5:0]  aluc;
  logic [31:0] alu_r;
  logic        alu_zero, alu_overflow;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        br_taken;
  logic [31:0] br_target;
  logic        br_abs;
  logic        done, illegal, exc_ovf;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] rf [32];

  mips_mc_ctrl #(.XLEN(32), .RF_AW(5)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data),
    .rt_data(rt_data), .alu_a(alu_a), .alu_b(alu_b), .aluc(aluc), .alu_r(alu_r),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .br_taken(br_taken),
    .br_target(br_target), .br_abs(br_abs), .done(done), .illegal(illegal),
    .exc_ovf(exc_ovf)
  );

  always #5 clk = ~clk;

  // Register file read data appears the cycle after the address
  always @(posedge clk) begin
    rs_data <= rf[rs_addr];
    rt_data <= rt_addr == 5'd0 ? 32'd0 : rf[rt_addr];
  end

  // ALU model for the operations exercised here
  always_comb begin
    alu_overflow = 1'b0;
    case (aluc)
      6'b100000, 6'b100001: begin
        alu_r = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      6'b100010, 6'b100011: begin
        alu_r = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31]) && (alu_r[31] != alu_a[31]);
      end
      6'b100100: alu_r = alu_a & alu_b;
      6'b100101: alu_r = alu_a | alu_b;
      6'b100110: alu_r = alu_a ^ alu_b;
      6'b000000: alu_r = alu_b << alu_a[4:0];
      6'b001111: alu_r = alu_a << 16;
      default:   alu_r = 32'd0;
    endcase
    alu_zero = (alu_r == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer an instruction in IDLE and advance to the EXEC cycle
  task automatic go_exec(input logic [31:0] ins);
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 32'hFC00_0000;
    chk("ready_busy", {31'd0, instr_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_retire(input string tag, input logic exp_wb, input logic [4:0] exp_wa,
                            input logic [31:0] exp_wd, input logic exp_br,
                            input logic exp_abs, input logic [31:0] exp_tgt,
                            input logic exp_ill, input logic exp_ovf);
    @(negedge clk);
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_wb_en"}, {31'd0, wb_en}, {31'd0, exp_wb});
    if (exp_wb) begin
      chk({tag, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, exp_wa});
      chk({tag, "_wb_data"}, wb_data, exp_wd);
    end
    chk({tag, "_br_taken"}, {31'd0, br_taken}, {31'd0, exp_br});
    if (exp_br) begin
      chk({tag, "_br_abs"}, {31'd0, br_abs}, {31'd0, exp_abs});
      chk({tag, "_br_target"}, br_target, exp_tgt);
    end
    chk({tag, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    chk({tag, "_exc_ovf"}, {31'd0, exc_ovf}, {31'd0, exp_ovf});
    @(negedge clk);
    chk({tag, "_done_low"}, {31'd0, done}, 32'd0);
    chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'd0;
    rf[1] = 32'd5;  rf[2] = 32'd7;  rf[7] = 32'd5;
    rf[9] = 32'h7FFF_FFFF;  rf[10] = 32'd1;
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_wb_en", {31'd0, wb_en}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_br", {31'd0, br_taken}, 32'd0);

    // ADD r3,r1,r2
    go_exec({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000});
    chk("add_aluc", {26'd0, aluc}, 32'h20);
    chk("add_a", alu_a, 32'd5);
    chk("add_b", alu_b, 32'd7);
    chk_retire("add", 1'b1, 5'd3, 32'd12, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // SLL r4,r2,3 with r2=1
    rf[2] = 32'd1;
    go_exec({6'd0, 5'd0, 5'd2, 5'd4, 5'd3, 6'b000000});
    chk("sll_aluc", {26'd0, aluc}, 32'h00);
    chk("sll_a", alu_a, 32'd3);
    chk("sll_b", alu_b, 32'd1);
    chk_retire("sll", 1'b1, 5'd4, 32'd8, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // ORI r5,r1,0x8001 (zero-extended)
    go_exec({6'b001101, 5'd1, 5'd5, 16'h8001});
    chk("ori_aluc", {26'd0, aluc}, 32'h25);
    chk("ori_b", alu_b, 32'h0000_8001);
    chk_retire("ori", 1'b1, 5'd5, 32'h0000_8005, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // ADDI r6,r1,0x8001 (sign-extended)
    go_exec({6'b001000, 5'd1, 5'd6, 16'h8001});
    chk("addi_aluc", {26'd0, aluc}, 32'h20);
    chk("addi_b", alu_b, 32'hFFFF_8001);
    chk_retire("addi", 1'b1, 5'd6, 32'hFFFF_8006, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // BEQ r1,r7,-2 with equal operands
    go_exec({6'b000100, 5'd1, 5'd7, 16'hFFFE});
    chk("beq_aluc", {26'd0, aluc}, 32'h23);
    chk_retire("beq", 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0, 1'b0);

    // BNE r1,r7,-2 with equal operands: no redirect
    go_exec({6'b000101, 5'd1, 5'd7, 16'hFFFE});
    chk_retire("bne", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // JR r1
    go_exec({6'd0, 5'd1, 15'd0, 6'b001000});
    chk_retire("jr", 1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 32'd5, 1'b0, 1'b0);

    // LUI r11,0x1234
    go_exec({6'b001111, 5'd0, 5'd11, 16'h1234});
    chk("lui_aluc", {26'd0, aluc}, 32'h0F);
    chk("lui_a", alu_a, 32'h0000_1234);
    chk_retire("lui", 1'b1, 5'd11, 32'h1234_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // ADDU r0,r1,r2: write to r0 suppressed, still retires
    go_exec({6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100001});
    chk_retire("wb_r0", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    // ADD r8,r9,r10: 0x7FFFFFFF + 1 overflows
    go_exec({6'd0, 5'd9, 5'd10, 5'd8, 5'd0, 6'b100000});
`ifdef TRAP_OVF_EN
    chk_retire("ovf", 1'b0, 5'd8, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
`else
    chk_retire("ovf", 1'b1, 5'd8, 32'h8000_0000, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
`endif

    // Opcode 111111 is illegal
    go_exec(32'hFC00_0000);
    chk_retire("illegal", 1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Reset while in EXEC discards the instruction
    go_exec({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstx_ready", {31'd0, instr_ready}, 32'd1);
    chk("rstx_done", {31'd0, done}, 32'd0);
    chk("rstx_wb_en", {31'd0, wb_en}, 32'd0);
    @(negedge clk);
    chk("rstx_done2", {31'd0, done}, 32'd0);

    // Controller recovers and runs the next instruction normally
    go_exec({6'b001101, 5'd1, 5'd12, 16'h0010});
    chk("post_rst_b", alu_b, 32'h0000_0010);
    chk_retire("post_rst", 1'b1, 5'd12, 32'h0000_0015, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
